program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Writer side of the fetch-stage instruction-memory write port. Takes a byte stream
//  (valid/ready) from a host link and assembles 16-bit instruction words. Drives
//  write_enable_fm/write_data_fm/write_addr_fm, and holds the core in fetch reset
//  (rst_fm) while a load is in progress.
// PARAMETERS
//  ADDR_W      32  width of write_addr_fm
//  START_ADDR  0   word address of the first loaded instruction
//  LEN_W       16  width of load_len (word count)
// PORTS
//  clk              in   1       system clock, rising edge
//  reset            in   1       asynchronous, active-low reset
//  load_start       in   1       1-cycle request to begin a load (honoured in IDLE only)
//  load_len         in   LEN_W   number of 16-bit words to load; sampled with load_start
//  byte_valid       in   1       host byte available
//  byte_data        in   8       host byte
//  byte_ready       out  1       loader accepts byte this cycle
//  write_enable_fm  out  1       instruction-memory write strobe
//  write_data_fm    out  16      instruction word
//  write_addr_fm    out  ADDR_W  instruction word address
//  rst_fm           out  1       active-high fetch/core hold while busy
//  busy             out  1       load in progress
//  done             out  1       1-cycle pulse at end of load
//  error            out  1       sticky checksum mismatch (CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE; byte_ready, write_enable_fm, rst_fm, busy,
//    done, error=0; write_data_fm=0; write_addr_fm=START_ADDR; word counter=0.
//  - Byte transfer occurs on a rising edge with byte_valid & byte_ready. Host may hold
//    byte_valid indefinitely. byte_data is ignored when no transfer occurs.
//  - FSM:
//    IDLE: byte_ready=0. When load_start=1: latch load_len, clear error,
//          set write_addr_fm=START_ADDR. If load_len=0, go to DONE; else go to LO.
//    LO:   byte_ready=1. On transfer, latch data[7:0] and go to HI.
//    HI:   byte_ready=1. On transfer, latch data[15:8] and go to WR.
//    WR:   byte_ready=0. write_enable_fm=1 for exactly this cycle, with stable
//          write_addr_fm/write_data_fm. Next edge: addr+=1 (wraps mod 2^ADDR_W),
//          count-=1. If count reaches 0, go to CHK (macro on) or DONE; else go to LO.
//    CHK:  byte_ready=1. On transfer, compare the byte with the running sum and go to DONE.
//    DONE: done=1 for one cycle, then go to IDLE.
//  - Byte order is little-endian: the first byte is the low half of the word.
//  - Minimum throughput is 3 cycles/word. Latency from the HI transfer edge to the
//    write strobe is 1 cycle.
//  - busy=1 and rst_fm=1 in every state except IDLE. Both are 0 in IDLE.
//  - load_start while busy is ignored; no restart.
//  - write_addr_fm holds the last written address + 1 after DONE until the next load_start.
//  - write_data_fm holds the last assembled word after WR.
//  - reset asserted mid-load: immediate return to IDLE with reset values. Already-written
//    words stay in memory; no partial word is ever written.
//  - load_len=2^LEN_W-1 is legal. The counter must not wrap early.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined:
//    - Running 8-bit sum (mod 256) of all data bytes, cleared at load_start.
//    - After the last WR, the CHK state accepts one checksum byte.
//    - Mismatch sets error=1 in the same cycle DONE begins. It holds until the next
//      load_start or reset.
//    - load_len=0 skips CHK.
//  Undefined: no CHK state, no sum register, error tied to 0.
// TESTING
//  1. Reset, load_start with load_len=2, bytes 34 12 CD AB:
//     writes 0x1234@0 then 0xABCD@1; each write_enable_fm 1 cycle; done once; rst_fm=0 after.
//  2. byte_valid toggled 1/0 every cycle for load_len=1 (bytes 0F F0):
//     exactly one write of 0xF00F@START_ADDR; no byte is lost or duplicated.
//  3. load_len=0: done pulses 2 cycles after load_start; no write_enable_fm; byte_ready never 1.
//  4. reset pulled low after 3 bytes of a 4-word load:
//     exactly one write occurred (0x1234@0); all outputs return to reset values.
//  5. LOADER_CHECKSUM_EN, load_len=1, bytes 01 02 then 03: error=0.
//     Repeat with checksum 04: error=1 at done.
//  6. load_start pulsed while busy (mid-load): ignored; address sequence continues unchanged.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream program loader: assembles little-endian 16-bit words from a valid/ready
// byte link and writes them into instruction memory. Define LOADER_CHECKSUM_EN to enable the trailing checksum byte.
module program_loader #(
  parameter int ADDR_W     = 32,
  parameter int START_ADDR = 0,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              write_enable_fm,
  output logic [15:0]       write_data_fm,
  output logic [ADDR_W-1:0] write_addr_fm,
  output logic              rst_fm,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WR,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  count;
  logic [7:0]        lo_byte;
  logic [15:0]       word;
  logic [ADDR_W-1:0] addr;
  logic              xfer;
  logic              start_ok;

  assign xfer     = byte_valid & byte_ready;
  assign start_ok = (state == S_IDLE) && load_start;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt       = state;
    byte_ready      = 1'b0;
    write_enable_fm = 1'b0;
    done            = 1'b0;
    case (state)
      S_IDLE: if (load_start) state_nxt = (load_len == '0) ? S_DONE : S_LO;
      S_LO: begin
        byte_ready = 1'b1;
        if (xfer) state_nxt = S_HI;
      end
      S_HI: begin
        byte_ready = 1'b1;
        if (xfer) state_nxt = S_WR;
      end
      S_WR: begin
        write_enable_fm = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        state_nxt = (count == LEN_W'(1)) ? S_CHK : S_LO;
`else
        state_nxt = (count == LEN_W'(1)) ? S_DONE : S_LO;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready = 1'b1;
        if (xfer) state_nxt = S_DONE;
      end
`endif
      S_DONE:  begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy   = (state != S_IDLE);
  assign rst_fm = busy;

  // The word register only changes on the high-byte transfer, so the write data stays
  // stable through the strobe and afterwards until the next full word is assembled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      lo_byte <= '0;
      word    <= '0;
      addr    <= START;
    end else begin
      if (start_ok) begin
        count <= load_len;
        addr  <= START;
      end
      if (state == S_LO && xfer) lo_byte <= byte_data;
      if (state == S_HI && xfer) word    <= {byte_data, lo_byte};
      if (state == S_WR) begin
        addr  <= addr + 1'b1;
        count <= count - 1'b1;
      end
    end
  end

  assign write_data_fm = word;
  assign write_addr_fm = addr;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       error_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum     <= '0;
      error_q <= 1'b0;
    end else begin
      if (start_ok) begin
        sum     <= '0;
        error_q <= 1'b0;
      end
      if ((state == S_LO || state == S_HI) && xfer) sum <= sum + byte_data;
      if (state == S_CHK && xfer) error_q <= (byte_data != sum);
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule
